// File: rtl/dsp_mult_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mult_pkg;
  localparam int unsigned DSP_W    = 32;
  localparam int unsigned PROD_W   = 64;
  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned ID_W     = $clog2(NREQ_MAX);

  // Sized for the largest supported requester count so one type serves every NREQ.
  typedef logic [ID_W-1:0] req_id_t;

  function automatic logic [NREQ_MAX-1:0] onehot(input req_id_t id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/DSP.sv
// Behavioural model of the shared 32x32 unsigned DSP multiplier primitive.
module DSP (
  output logic [63:0] res,
  input  logic [31:0] op1,
  input  logic [31:0] op2
);
  assign res = {32'b0, op1} * {32'b0, op2};
endmodule

// File: rtl/dsp_mult_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
import mult_pkg::*;

module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  req_id_t         ptr,
  output logic [NREQ-1:0] gnt,
  output req_id_t         gnt_id,
  output logic            any
);
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    // Inner loop keeps every bit select constant; k walks the search order from ptr.
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!any && req[i] && (i == (32'(ptr) + k) % NREQ)) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = req_id_t'(i);
        end
      end
    end
  end
endmodule

// File: rtl/dsp_mult_arbiter.sv
// Round-robin sharing of one DSP multiplier among NREQ requesters,
// with registered operand (S1) and product (S2) stages and backpressure.
import mult_pkg::*;

module dsp_mult_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = DSP_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_data,
  input  logic [NREQ-1:0]   rsp_ready
);
  logic [W-1:0]   op_a, op_b, sel_a, sel_b;
  logic [2*W-1:0] prod, res;
  req_id_t        s1_id, s2_id, rr_ptr, arb_id;
  logic           s1_v, s2_v, s2_stall, s1_accept, arb_any, take;
  logic [NREQ-1:0] arb_gnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  DSP u_dsp (
    .res (prod),
    .op1 (op_a),
    .op2 (op_b)
  );

  assign s2_stall  = s2_v & ~|(rsp_ready & NREQ'(onehot(s2_id)));
  assign s1_accept = ~s1_v | ~s2_stall;
  assign take      = arb_any & s1_accept & reset_n;
  assign req_ready = take ? arb_gnt : '0;
  assign rsp_valid = s2_v ? NREQ'(onehot(s2_id)) : '0;
  assign rsp_data  = res;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_id  <= '0;
      s2_id  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      rr_ptr <= '0;
    end else begin
      if (!s2_stall) begin
        s2_v  <= s1_v;
        s2_id <= s1_id;
        res   <= prod;
      end
      if (take) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        s1_id  <= arb_id;
        s1_v   <= 1'b1;
        rr_ptr <= (arb_id == req_id_t'(NREQ - 1)) ? '0 : arb_id + 1'b1;
      end else if (!s2_stall) begin
        s1_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// Directed self-checking bench for dsp_mult_arbiter (NREQ=4, W=32).
module tb_dsp_mult_arbiter;
  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [63:0]  rsp_data;
  int errors = 0;
  int checks = 0;

  dsp_mult_arbiter #(.NREQ(4), .W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 4'hF;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    req_a     = '0;
    req_b     = '0;
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    req_valid = '0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic test_single;
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early got=%b exp=0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_data !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL single_rsp_data got=%h exp=fffffffe00000001", rsp_data); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_fairness;
    logic [63:0] prodt [4];
    prodt = '{64'd22, 64'd39, 64'd85, 64'd133};
    do_reset();
    set_op(0, 32'd2, 32'd11);
    set_op(1, 32'd3, 32'd13);
    set_op(2, 32'd5, 32'd17);
    set_op(3, 32'd7, 32'd19);
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      if (k >= 2) begin
        checks++; if (rsp_valid !== 4'(1 << ((k - 2) % 4))) begin errors++; $display("FAIL fair_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, 4'(1 << ((k - 2) % 4))); end
        checks++; if (rsp_data !== prodt[(k - 2) % 4]) begin errors++; $display("FAIL fair_rsp_data k=%0d got=%0d exp=%0d", k, rsp_data, prodt[(k - 2) % 4]); end
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    rsp_ready = 4'b1101;
    set_op(1, 32'd6, 32'd7);
    set_op(2, 32'd4, 32'd9);
    set_op(3, 32'd10, 32'd10);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready0 got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b1100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_ready1 got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold_valid k=%0d got=%b exp=0010", k, rsp_valid); end
      checks++; if (rsp_data !== 64'd42) begin errors++; $display("FAIL bp_hold_data k=%0d got=%0d exp=42", k, rsp_data); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready k=%0d got=%b exp=0000", k, req_ready); end
      tick();
    end
    rsp_ready = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready); end
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_release_valid got=%b exp=0010", rsp_valid); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 64'd36) begin errors++; $display("FAIL bp_next got=%b/%0d exp=0100/36", rsp_valid, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 64'd100) begin errors++; $display("FAIL bp_last got=%b/%0d exp=1000/100", rsp_valid, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready0 got=%b exp=0001", req_ready); end
    tick();
    set_op(0, 32'd7, 32'd11);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready1 got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 64'd15) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=0001/15", rsp_valid, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 64'd77) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=0001/77", rsp_valid, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_reset_midflight;
    rsp_ready = 4'b0000;
    set_op(1, 32'd8, 32'd8);
    set_op(2, 32'd9, 32'd9);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL mid_full got=%b exp=0010", rsp_valid); end
    set_op(0, 32'd2, 32'd3);
    set_op(3, 32'd5, 32'd5);
    reset_n   = 1'b0;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0000", req_ready); end
    tick();
    reset_n   = 1'b1;
    rsp_ready = 4'hF;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_cleared got=%b exp=0000", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_second_grant got=%b exp=1000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_discarded got=%b exp=0000", rsp_valid); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 64'd6) begin errors++; $display("FAIL mid_rsp0 got=%b/%0d exp=0001/6", rsp_valid, rsp_data); end
    tick();
    checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 64'd25) begin errors++; $display("FAIL mid_rsp3 got=%b/%0d exp=1000/25", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_pointer_wrap;
    do_reset();
    set_op(2, 32'd9, 32'd9);
    set_op(3, 32'd100, 32'd3);
    set_op(0, 32'h0001_0000, 32'h0001_0000);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_g3 got=%b exp=1000", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_g0 got=%b exp=0001", req_ready); end
    checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 64'd81) begin errors++; $display("FAIL wrap_rsp2 got=%b/%0d exp=0100/81", rsp_valid, rsp_data); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_g3b got=%b exp=1000", req_ready); end
    checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 64'd300) begin errors++; $display("FAIL wrap_rsp3 got=%b/%0d exp=1000/300", rsp_valid, rsp_data); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 64'h1_0000_0000) begin errors++; $display("FAIL wrap_rsp0 got=%b/%h exp=0001/100000000", rsp_valid, rsp_data); end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_pointer_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
